// File: rtl/rib_arbiter_pkg.sv
//------------------------------------------------------------------------------
// rib_arbiter_pkg : shared widths, FSM and arbitration-mode encodings
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rib_arbiter_pkg;

  localparam int RibAddrBus = 32;
  localparam int RibDataBus = 32;

  typedef enum logic [1:0] {
    RIB_IDLE = 2'd0,
    RIB_BUSY = 2'd1,
    RIB_RESP = 2'd2
  } rib_state_e;

  typedef enum logic {
    ArbFixed      = 1'b0,
    ArbRoundRobin = 1'b1
  } rib_arb_mode_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int rib_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rib_prio_pick.sv
//------------------------------------------------------------------------------
// rib_prio_pick : first set request at or after a start pointer, wrapping
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rib_prio_pick
  import rib_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = rib_clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] k;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[k]) begin
        valid_o     = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rib_arbiter.sv
//------------------------------------------------------------------------------
// rib_arbiter : N-master to 1-slave serialising bus arbiter with ack timeout
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = RibAddrBus,
  parameter int DATA_W  = RibDataBus,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTERS-1:0]    m_req_i,
  input  logic [MASTERS-1:0]    m_we_i,
  input  logic [MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [MASTERS-1:0]    m_gnt_o,
  output logic [MASTERS-1:0]    m_rvalid_o,
  output logic [DATA_W-1:0]     m_rdata_o,
  output logic                  m_err_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  input  logic                  s_ack_i,
  input  logic [DATA_W-1:0]     s_rdata_i,
  output logic                  hold_flag_o
);

  localparam int IDX_W = rib_clog2_min1(MASTERS);
  localparam int CNT_W = rib_clog2_min1(TIMEOUT);

  rib_state_e          state_q, state_d;
  logic [MASTERS-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MASTERS-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    pick_ptr;
  logic [MASTERS-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                timeout_hit;
  logic [IDX_W-1:0]    ptr_next;

  // Fixed priority is round-robin with the search always starting at master 0.
  assign pick_ptr = (RR_MODE == int'(ArbRoundRobin)) ? ptr_q : '0;

  rib_prio_pick #(
    .N     (MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (m_req_i),
    .ptr_i     (pick_ptr),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  assign timeout_hit = (TIMEOUT > 0) && (int'(cnt_q) == TIMEOUT - 1);
  assign ptr_next    = (int'(idx_q) == MASTERS - 1) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      RIB_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          cnt_d   = '0;
          state_d = RIB_BUSY;
        end
      end
      RIB_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // An ack on the last timeout cycle still counts as a good completion.
        if (s_ack_i) begin
          rdata_d  = s_rdata_i;
          rvalid_d = gnt_q;
          ptr_d    = ptr_next;
          state_d  = RIB_RESP;
        end else if (timeout_hit) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          rvalid_d = gnt_q;
          ptr_d    = ptr_next;
          state_d  = RIB_RESP;
        end
      end
      RIB_RESP: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = RIB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = RIB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RIB_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    s_req_o   = (state_q == RIB_BUSY);
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (state_q == RIB_BUSY) begin
      s_we_o    = m_we_i[idx_q];
      s_addr_o  = m_addr_i[int'(idx_q)*ADDR_W +: ADDR_W];
      s_wdata_o = m_wdata_i[int'(idx_q)*DATA_W +: DATA_W];
    end
  end

  assign m_gnt_o     = gnt_q;
  assign m_rvalid_o  = rvalid_q;
  assign m_rdata_o   = rdata_q;
  assign m_err_o     = err_q;
  // Gated by reset so the pipeline is never stalled while the arbiter is held.
  assign hold_flag_o = rst & (|(m_req_i & ~rvalid_q));

endmodule

`default_nettype wire

// File: tb/tb_rib_arbiter.sv
//------------------------------------------------------------------------------
// tb_rib_arbiter : directed scoreboard bench, round-robin and fixed instances
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rib_arbiter;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [M-1:0]    req[2], we[2], gnt[2], rv[2];
  logic [M*AW-1:0] addr[2];
  logic [M*DW-1:0] wd[2];
  logic            ack[2], err[2], sreq[2], swe[2], hold[2];
  logic [DW-1:0]   srd[2], rdat[2], swdat[2];
  logic [AW-1:0]   sadr[2];

  typedef struct {
    logic [M-1:0]  gnt;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  rib_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst),
    .m_req_i(req[0]), .m_we_i(we[0]), .m_addr_i(addr[0]), .m_wdata_i(wd[0]),
    .m_gnt_o(gnt[0]), .m_rvalid_o(rv[0]), .m_rdata_o(rdat[0]), .m_err_o(err[0]),
    .s_req_o(sreq[0]), .s_we_o(swe[0]), .s_addr_o(sadr[0]), .s_wdata_o(swdat[0]),
    .s_ack_i(ack[0]), .s_rdata_i(srd[0]), .hold_flag_o(hold[0])
  );

  rib_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fx (
    .clk(clk), .rst(rst),
    .m_req_i(req[1]), .m_we_i(we[1]), .m_addr_i(addr[1]), .m_wdata_i(wd[1]),
    .m_gnt_o(gnt[1]), .m_rvalid_o(rv[1]), .m_rdata_o(rdat[1]), .m_err_o(err[1]),
    .s_req_o(sreq[1]), .s_we_o(swe[1]), .s_addr_o(sadr[1]), .s_wdata_o(swdat[1]),
    .s_ack_i(ack[1]), .s_rdata_i(srd[1]), .hold_flag_o(hold[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [M-1:0] oh);
    for (int i = 0; i < M; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Waits for a grant, services it (ack after ack_at busy cycles, or never
  // when ack_at < 0) and scores the completion against the queued expectation.
  task automatic run_txn(input int u, input string tag, input logic [M-1:0] exp_gnt,
                         input int ack_at, input logic [DW-1:0] rd, input bit drop);
    int   n;
    int   k;
    exp_t e;
    exp_t got;
    n = 0;
    while (gnt[u] == '0 && n < 8) begin
      step();
      n++;
    end
    k = idx_of(exp_gnt);
    chk({tag, ".gnt"},   gnt[u], exp_gnt);
    chk({tag, ".sreq"},  sreq[u], 1'b1);
    chk({tag, ".saddr"}, sadr[u], addr[u][k*AW +: AW]);
    chk({tag, ".swe"},   swe[u], we[u][k]);
    chk({tag, ".hold"},  hold[u], |req[u]);
    if (drop) req[u][k] = 1'b0;
    e.gnt   = exp_gnt;
    e.err   = (ack_at < 0);
    e.rdata = e.err ? '0 : rd;
    sb.push_back(e);
    n = 0;
    while (rv[u] == '0 && n < 40) begin
      ack[u] = (n == ack_at);
      srd[u] = rd;
      step();
      n++;
    end
    ack[u] = 1'b0;
    chk({tag, ".latency"}, n, (ack_at < 0) ? TO : ack_at + 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, ".rvalid"},  rv[u], got.gnt);
      chk({tag, ".rdata"},   rdat[u], got.rdata);
      chk({tag, ".err"},     err[u], got.err);
      chk({tag, ".hold_rv"}, hold[u], |(req[u] & ~got.gnt));
    end
    step();
    chk({tag, ".gnt_clr"}, gnt[u], '0);
    chk({tag, ".rv_clr"},  rv[u], '0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = '0; we[u] = '0; ack[u] = 1'b0; srd[u] = '0;
      addr[u] = {32'h0000_0400, 32'h0000_0300, 32'h0000_0100, 32'h0000_0080};
      wd[u]   = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    req[0] = 4'b1111;
    #1;
    chk("reset.gnt",  gnt[0], '0);
    chk("reset.rv",   rv[0], '0);
    chk("reset.sreq", sreq[0], 1'b0);
    chk("reset.hold", hold[0], 1'b0);
    chk("reset.rdata", rdat[0], '0);
    chk("reset.err",  err[0], 1'b0);
    step();
    req[0] = '0;
    rst = 1'b1;

    // single read from master 1
    req[0] = 4'b0010;
    run_txn(0, "single", 4'b0010, 0, 32'hDEAD_BEEF, 1'b0);
    req[0] = '0;

    // round-robin rotation from a fresh pointer
    rst = 1'b0; step(); rst = 1'b1;
    req[0] = 4'b1111;
    run_txn(0, "rr0", 4'b0001, 0, 32'h1111_0000, 1'b0);
    run_txn(0, "rr1", 4'b0010, 1, 32'h1111_0001, 1'b0);
    run_txn(0, "rr2", 4'b0100, 0, 32'h1111_0002, 1'b0);
    run_txn(0, "rr3", 4'b1000, 2, 32'h1111_0003, 1'b0);
    run_txn(0, "rr4", 4'b0001, 0, 32'h1111_0004, 1'b0);
    req[0] = '0;

    // timeout on a master-2 write; pointer must land on 3
    req[0] = 4'b0100; we[0] = 4'b0100;
    run_txn(0, "timeout", 4'b0100, -1, 32'hBAD0_BAD0, 1'b0);
    req[0] = 4'b1111; we[0] = '0;
    run_txn(0, "ptr_after_to", 4'b1000, 0, 32'h2222_2222, 1'b0);
    req[0] = '0;

    // ack on the final timeout cycle
    req[0] = 4'b0001;
    run_txn(0, "collide", 4'b0001, TO - 1, 32'h1234_5678, 1'b0);
    req[0] = '0;

    // requester withdraws while granted
    req[0] = 4'b0100;
    run_txn(0, "drop", 4'b0100, 0, 32'h5555_AAAA, 1'b1);
    req[0] = '0;

    // ack with nothing in flight
    ack[0] = 1'b1; srd[0] = 32'hFFFF_FFFF;
    step();
    chk("stray_ack.sreq", sreq[0], 1'b0);
    step();
    chk("stray_ack.rv", rv[0], '0);
    ack[0] = 1'b0;

    // reset during BUSY, then re-arbitrate from pointer 0
    req[0] = 4'b1000;
    begin
      int n;
      n = 0;
      while (gnt[0] == '0 && n < 8) begin step(); n++; end
    end
    chk("rstbusy.gnt_pre", gnt[0], 4'b1000);
    rst = 1'b0;
    #1;
    chk("rstbusy.sreq", sreq[0], 1'b0);
    chk("rstbusy.gnt",  gnt[0], '0);
    chk("rstbusy.hold", hold[0], 1'b0);
    step();
    chk("rstbusy.rv", rv[0], '0);
    rst = 1'b1;
    req[0] = 4'b1010;
    run_txn(0, "rstbusy.rearb", 4'b0010, 0, 32'h0BAD_F00D, 1'b0);
    req[0] = '0;

    // fixed priority instance always serves master 0
    req[1] = 4'b1111;
    run_txn(1, "fx0", 4'b0001, 0, 32'hF000_0000, 1'b0);
    run_txn(1, "fx1", 4'b0001, 1, 32'hF000_0001, 1'b0);
    run_txn(1, "fx2", 4'b0001, 0, 32'hF000_0002, 1'b0);
    run_txn(1, "fx3", 4'b0001, 0, 32'hF000_0003, 1'b0);
    req[1] = '0;

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
